// File: rtl/taho_monitor.sv
// Tachometer monitor: windowed moving average of per-second pulse counts,
// over/under-speed flags with hysteresis, and optional stall detection.
// Optional feature macro: TAHO_MONITOR_STALL_EN (stall detection; stall tied 0 when undefined).
module taho_monitor #(
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned HYST       = 8,
    parameter int unsigned STALL_SECS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sec,
    input  logic [15:0] freq,
    input  logic [15:0] lim_hi,
    input  logic [15:0] lim_lo,
    output logic [15:0] freq_avg,
    output logic        avg_valid,
    output logic        over_speed,
    output logic        under_speed,
    output logic        stall
);

    localparam int unsigned N      = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = 16 + AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;

    localparam logic [AVG_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [FILL_W-1:0]   FILL_ONE = 1;
    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(N);
    localparam logic [16:0]         HYST_17  = 17'(HYST);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOAD,
        ST_AVG,
        ST_CMP
    } state_t;

    state_t              state;
    logic                sec_d;
    logic                sec_rise;
    logic [1:0]          wait_cnt;
    logic [15:0]         win [N];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [FILL_W-1:0]   fill;
    logic [SUM_W-1:0]    sum;
    logic                win_full;
    logic [15:0]         evicted;
    logic [16:0]         hi_ext;
    logic [16:0]         lo_plus;
    logic [15:0]         over_clr_thr;
    logic [15:0]         under_clr_thr;

    // Edge detect, window status and hysteresis thresholds (saturating)
    always_comb begin
        sec_rise      = sec & ~sec_d;
        win_full      = (fill == FILL_MAX);
        evicted       = win_full ? win[wr_ptr] : 16'd0;
        hi_ext        = {1'b0, lim_hi};
        lo_plus       = {1'b0, lim_lo} + HYST_17;
        over_clr_thr  = (hi_ext > HYST_17) ? 16'(hi_ext - HYST_17) : 16'd0;
        under_clr_thr = lo_plus[16] ? 16'hFFFF : lo_plus[15:0];
    end

    // Sample sequencer, window/running-sum update and flag evaluation
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            // Tracking sec during reset suppresses a false edge when sec is
            // already high at release; it reads 0 whenever sec is low.
            sec_d       <= sec;
            wait_cnt    <= 2'd0;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            freq_avg    <= 16'd0;
            avg_valid   <= 1'b0;
            over_speed  <= 1'b0;
            under_speed <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                win[i] <= 16'd0;
            end
        end else begin
            sec_d     <= sec;
            avg_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sec_rise) begin
                        wait_cnt <= 2'd0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd2) begin
                        state <= ST_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_LOAD: begin
                    win[wr_ptr] <= freq;
                    wr_ptr      <= wr_ptr + PTR_ONE;
                    sum         <= sum + SUM_W'(freq) - SUM_W'(evicted);
                    if (!win_full) begin
                        fill <= fill + FILL_ONE;
                    end
                    state <= ST_AVG;
                end
                ST_AVG: begin
                    if (win_full) begin
                        freq_avg <= 16'(sum >> AVG_LOG2);
                    end
                    state <= ST_CMP;
                end
                ST_CMP: begin
                    if (win_full) begin
                        avg_valid <= 1'b1;
                        if (freq_avg > lim_hi) begin
                            over_speed <= 1'b1;
                        end else if (freq_avg < over_clr_thr) begin
                            over_speed <= 1'b0;
                        end
                        if (freq_avg < lim_lo) begin
                            under_speed <= 1'b1;
                        end else if (freq_avg > under_clr_thr) begin
                            under_speed <= 1'b0;
                        end
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TAHO_MONITOR_STALL_EN
    logic [3:0] zero_cnt;
    logic [4:0] zero_next;

    // Next zero-run length, saturating at the counter maximum
    always_comb begin
        zero_next = (zero_cnt == 4'hF) ? 5'd15 : 5'(zero_cnt) + 5'd1;
    end

    // Consecutive-zero counting on the raw captured sample
    always_ff @(posedge clock) begin
        if (reset) begin
            zero_cnt <= 4'd0;
            stall    <= 1'b0;
        end else if (state == ST_LOAD) begin
            if (freq == 16'd0) begin
                zero_cnt <= zero_next[3:0];
                stall    <= (zero_next >= 5'(STALL_SECS));
            end else begin
                zero_cnt <= 4'd0;
                stall    <= 1'b0;
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

endmodule
